// File: rtl/cmp16_serial.sv
`default_nettype none
// ============================================================================
// Module      : cmp16_serial
// Description : Serial 16-bit unsigned magnitude comparator, one nibble per
//               clock, LSB nibble first, with optional cascade inputs enabled
//               by the CMP16_CASCADE_IN_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp16_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        AlBin,
   input  logic        AnBin,
   input  logic        AbBin,
   output logic        busy,
   output logic        done,
   output logic        AlB,
   output logic        AnB,
   output logic        AbB
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] RES_GT = 3'b100;
   localparam logic [2:0] RES_LT = 3'b010;
   localparam logic [2:0] RES_EQ = 3'b001;

   logic [1:0]  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [2:0]  res_q, res_d;
   logic [2:0]  out_q, out_d;

   logic [2:0]  init_res;
   logic [3:0]  a_nib;
   logic [3:0]  b_nib;
   logic [2:0]  nib_res;

`ifdef CMP16_CASCADE_IN_EN
   // Contradictory cascade codes are carried through so they surface only on a full tie.
   always_comb begin
      init_res = RES_EQ;
      if (AbBin) begin
         init_res = RES_EQ;
      end else begin
         case ({AlBin, AnBin})
            2'b10:   init_res = RES_GT;
            2'b01:   init_res = RES_LT;
            2'b11:   init_res = 3'b000;
            default: init_res = 3'b110;
         endcase
      end
   end
`else
   logic unused_cascade;
   assign unused_cascade = AlBin ^ AnBin ^ AbBin;
   assign init_res       = RES_EQ;
`endif

   assign a_nib = a_q[{cnt_q, 2'b00} +: 4];
   assign b_nib = b_q[{cnt_q, 2'b00} +: 4];

   // A later (more significant) nibble that differs overrides everything below it.
   always_comb begin
      nib_res = res_q;
      if (a_nib > b_nib) begin
         nib_res = RES_GT;
      end else if (a_nib < b_nib) begin
         nib_res = RES_LT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         a_q   <= 16'd0;
         b_q   <= 16'd0;
         res_q <= 3'b000;
         out_q <= 3'b000;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
         out_q <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cnt_q == 2'd3) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      out_d = out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d   = A;
               b_d   = B;
               res_d = init_res;
               cnt_d = 2'd0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 2'd1;
            res_d = nib_res;
            if (cnt_q == 2'd3) begin
               out_d = nib_res;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_RUN:  busy = 1'b1;
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   assign AlB = out_q[2];
   assign AnB = out_q[1];
   assign AbB = out_q[0];

endmodule
`default_nettype wire

// File: tb/tb_cmp16_serial.sv
`default_nettype none
// Testbench for cmp16_serial: scoreboard of expected {AlB,AnB,AbB} values
// pushed at start and popped when done is observed.
module tb_cmp16_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic [2:0]  casc;
   logic        busy;
   logic        done;
   logic        AlB;
   logic        AnB;
   logic        AbB;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2:0] exp_q[$];

   cmp16_serial dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .AlBin (casc[2]),
      .AnBin (casc[1]),
      .AbBin (casc[0]),
      .busy  (busy),
      .done  (done),
      .AlB   (AlB),
      .AnB   (AnB),
      .AbB   (AbB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] c);
      if (a > b) return 3'b100;
      if (a < b) return 3'b010;
`ifdef CMP16_CASCADE_IN_EN
      if (c[0])         return 3'b001;
      if (c == 3'b100)  return 3'b100;
      if (c == 3'b010)  return 3'b010;
      if (c == 3'b110)  return 3'b000;
      return 3'b110;
`else
      return (c == c) ? 3'b001 : 3'b001;
`endif
   endfunction

   // Called at a negedge in IDLE; returns at the negedge after DONE (back in IDLE).
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                          output logic [2:0] got, output int lat);
      A = a;
      B = b;
      casc = c;
      start = 1'b1;
      exp_q.push_back(ref_cmp(a, b, c));
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      got = {AlB, AnB, AbB};
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic [2:0] e;
      int lat;
      rst_n = 1'b0;
      start = 1'b1;
      A = 16'h00F0;
      B = 16'h000F;
      casc = 3'b001;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++;
      if ({AlB, AnB, AbB} !== 3'b000) begin
         n_fail++; $display("FAIL reset_outs got=%b exp=000", {AlB, AnB, AbB});
      end
      exp_q.push_back(ref_cmp(16'h00F0, 16'h000F, 3'b001));
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL first_start_busy got=%b exp=1", busy); end
      lat = 1;
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (lat !== 5) begin n_fail++; $display("FAIL first_start_latency got=%0d exp=5", lat); end
      n_checks++;
      if ({AlB, AnB, AbB} !== e) begin
         n_fail++; $display("FAIL first_start_result got=%b exp=%b", {AlB, AnB, AbB}, e);
      end
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [2:0] got, e;
      int lat;
      run_txn(16'h5A3C, 16'h5A3B, 3'b001, got, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (lat !== 5) begin n_fail++; $display("FAIL basic_gt_latency got=%0d exp=5", lat); end
      n_checks++;
      if (got !== 3'b100 || e !== 3'b100) begin
         n_fail++; $display("FAIL basic_gt got=%b exp=100 model=%b", got, e);
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_done busy=%b done=%b exp=0,0", busy, done);
      end
      run_txn(16'h1234, 16'h8000, 3'b001, got, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== 3'b010 || e !== 3'b010) begin
         n_fail++; $display("FAIL basic_msb_lt got=%b exp=010 model=%b", got, e);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({AlB, AnB, AbB} !== 3'b010) begin
         n_fail++; $display("FAIL result_hold got=%b exp=010", {AlB, AnB, AbB});
      end
   endtask

   task automatic test_cascade;
      logic [2:0] cin  [5];
      logic [2:0] cexp [5];
      logic [2:0] got, e;
      int lat;
      cin = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b000};
`ifdef CMP16_CASCADE_IN_EN
      cexp = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b110};
`else
      cexp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
      for (int i = 0; i < 5; i++) begin
         run_txn(16'hBEEF, 16'hBEEF, cin[i], got, lat);
         e = exp_q.pop_front();
         n_checks++;
         if (got !== cexp[i] || e !== cexp[i]) begin
            n_fail++;
            $display("FAIL cascade_%b got=%b exp=%b model=%b", cin[i], got, cexp[i], e);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic pat [15];
      int ndone, t1, t2;
      logic [2:0] e;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ndone = 0;
      t1 = -1;
      t2 = -1;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) begin
            ndone++;
            if (t1 < 0) t1 = i; else t2 = i;
            e = exp_q.pop_front();
            n_checks++;
            if ({AlB, AnB, AbB} !== e) begin
               n_fail++; $display("FAIL b2b_result_%0d got=%b exp=%b", ndone, {AlB, AnB, AbB}, e);
            end
         end
         start = pat[i];
         casc = 3'b001;
         if (i == 0) begin
            A = 16'h0100; B = 16'h00FF;
            exp_q.push_back(ref_cmp(A, B, casc));
         end else if (i == 6) begin
            A = 16'h7777; B = 16'h7778;
            exp_q.push_back(ref_cmp(A, B, casc));
         end else begin
            A = 16'hFFFF; B = 16'h0000;
         end
         @(negedge clk);
      end
      n_checks++;
      if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
      n_checks++;
      if (t1 !== 5 || t2 - t1 !== 6) begin
         n_fail++; $display("FAIL b2b_spacing first=%0d spacing=%0d exp=5,6", t1, t2 - t1);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [2:0] got, e;
      int lat;
      int bad;
      A = 16'hAAAA;
      B = 16'h5555;
      casc = 3'b001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {AlB, AnB, AbB} !== 3'b000) begin
         n_fail++;
         $display("FAIL midrun_reset busy=%b done=%b outs=%b exp=0,0,000", busy, done, {AlB, AnB, AbB});
      end
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL midrun_no_done got=%0d bad cycles exp=0", bad); end
      run_txn(16'h0F00, 16'h0E99, 3'b001, got, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== 3'b100 || e !== 3'b100 || lat !== 5) begin
         n_fail++; $display("FAIL after_reset got=%b lat=%0d exp=100 lat=5", got, lat);
      end
   endtask

   task automatic test_random;
      logic [2:0] got, e;
      logic [15:0] a, b;
      int lat;
      for (int i = 0; i < 10000; i++) begin
         a = 16'($urandom);
         b = (i % 8 == 0) ? a ^ (16'h1 << $urandom_range(0, 15)) : 16'($urandom);
         if (i % 64 == 1) b = a;
         run_txn(a, b, 3'b001, got, lat);
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e || lat !== 5) begin
            n_fail++; $display("FAIL random A=%h B=%h got=%b lat=%0d exp=%b lat=5", a, b, got, lat, e);
         end
         n_checks++;
         if (!$onehot(got)) begin
            n_fail++; $display("FAIL random_onehot A=%h B=%h got=%b exp=one-hot", a, b, got);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A = 16'd0;
      B = 16'd0;
      casc = 3'b001;
      test_reset();
      test_basic();
      test_cascade();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++; $display("FAIL scoreboard_empty got=%0d left exp=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmp16_serial.md
CMP16_SERIAL -- requirements
Module: cmp16_serial

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is asynchronous and active-low; the ports SHALL be named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to compare; sampled only in IDLE.
REQ-005 A  input  16  operand A; captured on an accepted start.
REQ-006 B  input  16  operand B; captured on an accepted start.
REQ-007 AlBin  input  1  cascade input, A>B from the less-significant stage.
REQ-008 AnBin  input  1  cascade input, A<B from the less-significant stage.
REQ-009 AbBin  input  1  cascade input, A=B from the less-significant stage.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  single-cycle pulse; results are valid.
REQ-012 AlB  output  1  result A>B (registered).
REQ-013 AnB  output  1  result A<B (registered).
REQ-014 AbB  output  1  result A=B (registered).

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after 4 RUN cycles.
- DONE->IDLE unconditionally after 1 cycle.
REQ-016 An accepted start SHALL capture A, B and the cascade result, clear the 2-bit nibble counter to 0, and set busy=1 on the same edge.
REQ-017 Each RUN cycle SHALL compare nibble k (k=counter, k=0 is bits 3:0), LSB nibble first.
- A nibble > B nibble: running result = GT.
- A nibble < B nibble: running result = LT.
- Nibbles equal: running result is kept.
- Counter increments by 1 each RUN cycle.
REQ-018 The unsigned 16-bit result SHALL therefore equal an MSB-first comparison of four cascaded 4-bit comparators.
REQ-019 On the RUN->DONE edge, the running result SHALL be written to AlB/AnB/AbB.
REQ-020 In DONE, done=1 and busy=1; in IDLE, done=0 and busy=0.
REQ-021 Latency SHALL be 5 clocks from the start-sampling edge to the done pulse.
REQ-022 AlB/AnB/AbB SHALL hold their value until the next DONE, or until reset.
REQ-023 start SHALL be ignored in RUN and DONE; a start sampled in the IDLE cycle following DONE SHALL be accepted (back-to-back throughput: 1 result per 6 clocks).
REQ-024 The counter SHALL wrap 3->0 only on RUN->DONE and SHALL never index past nibble 3.

Reset
REQ-025 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-026 While rst_n=0, the block SHALL hold busy=0, done=0, AlB=0, AnB=0, AbB=0, counter=0 and captured operands=0.
REQ-027 A reset asserted mid-RUN or mid-DONE SHALL abort the comparison with no done pulse.
REQ-028 The first accepted start SHALL be the first edge with rst_n=1 and start=1.

Configuration
REQ-029 The macro CMP16_CASCADE_IN_EN SHALL select the initial running result (at capture) as follows.
- When defined, the initial result SHALL be derived from {AlBin,AnBin,AbBin}: 100->GT, 010->LT, xx1->EQ, 110->result {0,0,0}, 000->result {1,1,0}.
- The 110 and 000 results SHALL survive only if all nibbles are equal.
- When undefined, the initial result SHALL be EQ, and AlBin/AnBin/AbBin SHALL be unused.

Verification
REQ-030 Start with A=0x5A3C, B=0x5A3B, cascade=001 -> done after 5 clocks; AlB,AnB,AbB = 1,0,0.
REQ-031 Start with A=0x1234, B=0x8000 -> result 0,1,0 (MSB nibble overrides a lower GT).
REQ-032 A=B=0xBEEF, sweep the cascade inputs over 100/010/001/110/000 with the macro defined -> results 100/010/001/000/110; with the macro undefined -> 001 for every cascade value.
REQ-033 Start pulsed again during RUN cycles 2-3 -> ignored, exactly one done pulse; start in the IDLE cycle after DONE -> accepted, second done 6 clocks after the first.
REQ-034 rst_n dropped during RUN cycle 3 -> busy=0 and outputs 000 immediately, no done pulse; the next start completes normally.
REQ-035 Random 10k A/B pairs -> results match a reference unsigned compare, with exactly one of AlB/AnB/AbB high.
